// File: rtl/alu_pkg.sv
// Shared encodings for the sequential ALU: operation select codes and FSM states.
package alu_pkg;

   localparam logic [1:0] OP_ADD  = 2'b00;
   localparam logic [1:0] OP_SUB  = 2'b01;
   localparam logic [1:0] OP_MUL  = 2'b10;
   localparam logic [1:0] OP_PASS = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_MUL  = 2'b01,
      ST_DONE = 2'b10
   } state_t;

endpackage

// File: rtl/mul_shift_add.sv
// Fixed-latency shift-add multiplier: W iterations after start, no early exit.
// done/product are combinational in the final iteration so the caller can
// register the product on the same edge the multiplier goes idle.
module mul_shift_add #(
   parameter int W = 4
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           start,
   input  logic [W-1:0]   a,
   input  logic [W-1:0]   b,
   output logic           busy,
   output logic           done,
   output logic [2*W-1:0] product
);

   localparam int CW = (W > 1) ? $clog2(W) : 1;

   logic [2*W-1:0] mcand;
   logic [2*W-1:0] acc;
   logic [2*W-1:0] acc_next;
   logic [W-1:0]   mplier;
   logic [CW-1:0]  count;

   // Partial-product add for the current multiplier bit.
   always_comb begin
      acc_next = acc;
      if (mplier[0]) begin
         acc_next = acc + mcand;
      end
   end

   assign done    = busy && (count == CW'(W - 1));
   assign product = acc_next;

   // Operand load on start, then one shift-add step per cycle while busy.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mcand  <= '0;
         mplier <= '0;
         acc    <= '0;
         count  <= '0;
         busy   <= 1'b0;
      end else if (start) begin
         mcand  <= {{W{1'b0}}, a};
         mplier <= b;
         acc    <= '0;
         count  <= '0;
         busy   <= 1'b1;
      end else if (busy) begin
         acc    <= acc_next;
         mcand  <= mcand << 1;
         mplier <= mplier >> 1;
         count  <= count + 1'b1;
         if (done) begin
            busy <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/alu_seq.sv
// Sequential add/sub/mul/pass ALU with valid/ready handshakes on both sides.
module alu_seq
   import alu_pkg::*;
#(
   parameter int W = 4
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic [1:0]     select,
   input  logic [W-1:0]   x,
   input  logic [W-1:0]   y,
   input  logic           in_valid,
   output logic           in_ready,
   output logic [2*W-1:0] f,
   output logic           carry,
   output logic           zero,
   output logic           out_valid,
   input  logic           out_ready
);

   state_t         state;
   state_t         state_next;
   logic           accept;
   logic           mul_start;
   logic           mul_busy;
   logic           mul_done;
   logic [2*W-1:0] mul_product;
   logic [2*W-1:0] xe;
   logic [2*W-1:0] ye;
   logic [2*W-1:0] alu_f;
   logic           alu_c;

   assign in_ready  = (state == ST_IDLE) || ((state == ST_DONE) && out_ready);
   assign accept    = in_valid && in_ready;
   assign mul_start = accept && (select == OP_MUL);
   assign out_valid = (state == ST_DONE);

   mul_shift_add #(
      .W (W)
   ) u_mul (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (mul_start),
      .a       (x),
      .b       (y),
      .busy    (mul_busy),
      .done    (mul_done),
      .product (mul_product)
   );

   // Single-cycle datapath; operands are consumed at the accept edge, so the
   // result register stands in for separate select/x/y latches.
   always_comb begin
      xe    = {{W{1'b0}}, x};
      ye    = {{W{1'b0}}, y};
      alu_f = xe;
      alu_c = 1'b0;
      case (select)
         OP_ADD: begin
            alu_f = xe + ye;
            alu_c = alu_f[W];
         end
         OP_SUB: begin
            alu_f = xe - ye;
            alu_c = (x < y);
         end
         default: begin
            alu_f = xe;
            alu_c = 1'b0;
         end
      endcase
   end

   // Handshake FSM next state; an accept from DONE restarts exactly as from IDLE.
   always_comb begin
      state_next = state;
      if (accept) begin
         state_next = mul_start ? ST_MUL : ST_DONE;
      end else begin
         case (state)
            ST_IDLE: state_next = ST_IDLE;
            ST_MUL: begin
               if (mul_done) begin
                  state_next = ST_DONE;
               end else if (!mul_busy) begin
                  state_next = ST_IDLE;
               end
            end
            ST_DONE: begin
               if (out_ready) begin
                  state_next = ST_IDLE;
               end
            end
            default: state_next = ST_IDLE;
         endcase
      end
   end

   // FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Result registers; held while DONE waits for out_ready.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         f     <= '0;
         carry <= 1'b0;
         zero  <= 1'b0;
      end else if (accept && !mul_start) begin
         f     <= alu_f;
         carry <= alu_c;
         zero  <= (alu_f == '0);
      end else if (mul_done) begin
         f     <= mul_product;
         carry <= 1'b0;
         zero  <= (mul_product == '0);
      end
   end

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq (W=4): transaction-level model plus directed vectors.
module tb_alu_seq;

   localparam int W  = 4;
   localparam int W2 = 2 * W;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [1:0]    select = 2'b00;
   logic [W-1:0]  x = '0;
   logic [W-1:0]  y = '0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [W2-1:0] f;
   logic          carry;
   logic          zero;
   logic          out_valid;
   logic          out_ready = 1'b0;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   alu_seq #(
      .W (W)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .select    (select),
      .x         (x),
      .y         (y),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .f         (f),
      .carry     (carry),
      .zero      (zero),
      .out_valid (out_valid),
      .out_ready (out_ready)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference arithmetic from the operation definitions.
   task automatic ref_op(input logic [1:0] sel, input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W2-1:0] rf, output logic rc);
      int ia;
      int ib;
      ia = int'(a);
      ib = int'(b);
      case (sel)
         2'b00: begin rf = W2'(ia + ib); rc = ((ia + ib) >= (1 << W)); end
         2'b01: begin rf = W2'(ia - ib); rc = (ia < ib); end
         2'b10: begin rf = W2'(ia * ib); rc = 1'b0; end
         default: begin rf = W2'(ia); rc = 1'b0; end
      endcase
   endtask

   // Transaction model: one result slot, a countdown for multiply latency.
   logic          m_valid = 1'b0;
   int            m_busy = 0;
   logic [W2-1:0] m_f = '0;
   logic          m_c = 1'b0;
   logic [W2-1:0] p_f = '0;
   logic          p_c = 1'b0;

   function automatic logic m_ready();
      return (m_busy == 0 && !m_valid) || (m_valid && out_ready);
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_valid = 1'b0;
         m_busy  = 0;
      end else begin
         logic acc;
         acc = in_valid && m_ready();
         if (m_valid && out_ready) m_valid = 1'b0;
         if (m_busy > 0) begin
            m_busy--;
            if (m_busy == 0) begin
               m_valid = 1'b1;
               m_f     = p_f;
               m_c     = p_c;
            end
         end
         if (acc) begin
            ref_op(select, x, y, p_f, p_c);
            if (select == 2'b10) begin
               m_busy = W;
            end else begin
               m_valid = 1'b1;
               m_f     = p_f;
               m_c     = p_c;
            end
         end
      end
   end

   // Every-cycle comparison against the model.
   always @(negedge clk) begin
      if (rst_n) begin
         check("cmp_out_valid", 32'(out_valid), 32'(m_valid));
         check("cmp_in_ready", 32'(in_ready), 32'(m_ready()));
         if (m_valid) begin
            check("cmp_f", 32'(f), 32'(m_f));
            check("cmp_carry", 32'(carry), 32'(m_c));
            check("cmp_zero", 32'(zero), 32'(m_f == '0));
         end
      end
   end

   task automatic check_reset_state(input string tag);
      check({tag, "_f"}, 32'(f), 32'h0);
      check({tag, "_out_valid"}, 32'(out_valid), 32'h0);
      check({tag, "_carry"}, 32'(carry), 32'h0);
      check({tag, "_zero"}, 32'(zero), 32'h0);
      check({tag, "_in_ready"}, 32'(in_ready), 32'h1);
   endtask

   // One operation with out_ready high; checks latency and hand-computed result.
   task automatic run_op(input string name, input logic [1:0] sel, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [W2-1:0] ef, input logic ec,
                         input int elat);
      int lat;
      int rdy_seen;
      @(posedge clk); #2;
      select = sel; x = a; y = b; in_valid = 1'b1; out_ready = 1'b1;
      @(posedge clk); #2;
      in_valid = 1'b0;
      x = W'($urandom); y = W'($urandom); select = 2'($urandom);
      lat = 1;
      rdy_seen = 0;
      while (!out_valid && lat < 20) begin
         if (in_ready) rdy_seen++;
         @(posedge clk); #2;
         lat++;
      end
      check({name, "_latency"}, 32'(lat), 32'(elat));
      check({name, "_f"}, 32'(f), 32'(ef));
      check({name, "_carry"}, 32'(carry), 32'(ec));
      check({name, "_zero"}, 32'(zero), 32'(ef == '0));
      if (elat > 1) check({name, "_busy_ready"}, 32'(rdy_seen), 32'h0);
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b1;
      #1 check_reset_state("reset");

      run_op("add_f_1", 2'b00, 4'hF, 4'h1, 8'h10, 1'b1, 1);
      run_op("add_0_0", 2'b00, 4'h0, 4'h0, 8'h00, 1'b0, 1);
      run_op("add_9_8", 2'b00, 4'h9, 4'h8, 8'h11, 1'b1, 1);
      run_op("sub_3_5", 2'b01, 4'h3, 4'h5, 8'hFE, 1'b1, 1);
      run_op("sub_5_3", 2'b01, 4'h5, 4'h3, 8'h02, 1'b0, 1);
      run_op("sub_0_f", 2'b01, 4'h0, 4'hF, 8'hF1, 1'b1, 1);
      run_op("mul_f_f", 2'b10, 4'hF, 4'hF, 8'hE1, 1'b0, 5);
      run_op("mul_f_0", 2'b10, 4'hF, 4'h0, 8'h00, 1'b0, 5);
      run_op("mul_3_5", 2'b10, 4'h3, 4'h5, 8'h0F, 1'b0, 5);
      run_op("pass_c", 2'b11, 4'hC, 4'h3, 8'h0C, 1'b0, 1);

      // Backpressure: add held for 3 cycles, then back-to-back pass on release.
      @(posedge clk); #2;
      select = 2'b00; x = 4'h7; y = 4'h6; in_valid = 1'b1; out_ready = 1'b0;
      @(posedge clk); #2;
      in_valid = 1'b0; x = 4'h1; y = 4'h1; select = 2'b01;
      for (int i = 0; i < 3; i++) begin
         check("bp_valid", 32'(out_valid), 32'h1);
         check("bp_f", 32'(f), 32'h0D);
         check("bp_in_ready", 32'(in_ready), 32'h0);
         @(posedge clk); #2;
      end
      out_ready = 1'b1; in_valid = 1'b1; select = 2'b11; x = 4'hA; y = 4'h5;
      #1 check("b2b_in_ready", 32'(in_ready), 32'h1);
      @(posedge clk); #2;
      in_valid = 1'b0;
      check("b2b_valid", 32'(out_valid), 32'h1);
      check("b2b_f", 32'(f), 32'h0A);
      check("b2b_carry", 32'(carry), 32'h0);

      // Abort: reset during the second MUL cycle discards the product.
      @(posedge clk); #2;
      select = 2'b10; x = 4'h7; y = 4'h9; in_valid = 1'b1;
      @(posedge clk); #2;
      in_valid = 1'b0;
      @(posedge clk); #2;
      rst_n = 1'b0;
      #1 check("abort_async_valid", 32'(out_valid), 32'h0);
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b1;
      #1 check_reset_state("abort_reset");
      for (int i = 0; i < 8; i++) begin
         @(posedge clk); #2;
         check("abort_no_valid", 32'(out_valid), 32'h0);
      end
      run_op("mul_2_3", 2'b10, 4'h2, 4'h3, 8'h06, 1'b0, 5);

      @(posedge clk); #2;
      out_ready = 1'b0;
      repeat (2) @(posedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised sequential successor to the team's 4-bit add/sub/mul/pass ALU mux. Operand width is a parameter, and operation select encoding is unchanged. Add, sub and pass complete in one cycle; multiply runs as a multi-cycle shift-add. Operands and result use valid/ready handshakes so the block can sit between a register-file read stage and a writeback stage with backpressure.

## Interface
Parameters:
- W, 4, operand width in bits (W >= 2); result width is 2W.

Ports:
- clk  input  1  single system clock; all state updates on rising edge.
- rst_n  input  1  reset; asynchronous, active-low.
- select  input  2  operation: 00 add, 01 sub, 10 mul, 11 pass x.
- x  input  W  operand A, unsigned.
- y  input  W  operand B, unsigned.
- in_valid  input  1  operand/select valid.
- in_ready  output  1  block accepts operands this cycle.
- f  output  2W  result.
- carry  output  1  add carry-out, or sub borrow (x < y); 0 for mul/pass.
- zero  output  1  f == 0.
- out_valid  output  1  f/carry/zero valid.
- out_ready  input  1  consumer accepts result.

## Operation
- States: IDLE, MUL, DONE.
- Accept occurs when in_valid && in_ready. select, x and y are registered on accept and ignored otherwise.
- in_ready = (state == IDLE) || (state == DONE && out_ready). This is a combinational path from out_ready.
- Accept with select != 10:
  - Result is computed from the latched operands and registered.
  - Next state is DONE.
- Accept with select == 10:
  - Load multiplicand = x (zero-extended to 2W), multiplier = y, acc = 0, count = 0.
  - Next state is MUL.
- MUL, each cycle:
  - If multiplier[0], then acc += multiplicand.
  - multiplicand <<= 1, multiplier >>= 1, count++.
  - After W iterations (count == W-1 this cycle), f = final acc and next state is DONE.
  - There is no early exit on multiplier == 0, so latency is fixed.
- DONE:
  - out_valid = 1; f, carry and zero are held stable until out_ready.
  - On out_ready without a new accept, next state is IDLE.
  - On out_ready with a simultaneous accept, the new operation starts exactly as from IDLE, giving back-to-back operation.
- Arithmetic rules:
  - add: f = zero-extended x + y (W+1 significant bits); carry = bit W of the sum.
  - sub: f = (x - y) mod 2^(2W), with operands zero-extended to 2W, so a negative result is two's complement across all 2W bits; carry = (x < y).
  - mul: f = x*y as a full 2W-bit product; carry = 0.
  - pass: f = zero-extended x; carry = 0.
- zero is registered with f and always equals (f == 0) while out_valid is high.
- Reset (asynchronous, any state including mid-MUL):
  - state = IDLE, out_valid = 0, f = 0, carry = 0, zero = 0.
  - The in-flight operation is discarded and no result is emitted for it.
- Reset values: out_valid 0, f 0, carry 0, zero 0, in_ready 1 (IDLE).

## Timing
- Add/sub/pass: accept in cycle N → out_valid high in cycle N+1.
- Mul: accept in cycle N → MUL in cycles N+1..N+W → out_valid high in cycle N+W+1.
- Throughput:
  - With out_ready held high, one add/sub/pass per cycle.
  - One mul per W+1 cycles.
- While out_valid && !out_ready: f, carry and zero are frozen and in_ready is 0.
- Inputs are not sampled outside an accept cycle, so x/y/select may change freely.

## Structure
- Shared package alu_pkg holds:
  - op encodings OP_ADD = 2'b00, OP_SUB = 2'b01, OP_MUL = 2'b10, OP_PASS = 2'b11;
  - state encodings ST_IDLE, ST_MUL, ST_DONE.
- One sub-module, mul_shift_add (parameter W):
  - inputs: start, a, b;
  - outputs: busy, done, product[2W-1:0];
  - owns the multiplicand/multiplier/acc/count registers.
- The top level owns the handshake FSM, the single-cycle datapath and the output registers.

## Test plan
All scenarios use W=4.
- Reset: assert rst_n low for 2 cycles mid-stream → f=8'h00, out_valid=0, carry=0, zero=0, in_ready=1 after release.
- add: select=00, x=4'hF, y=4'h1, out_ready=1 → next cycle f=8'h10, carry=1, zero=0. Then x=0, y=0 → f=8'h00, zero=1.
- sub: select=01, x=3, y=5 → f=8'hFE, carry=1. Then x=5, y=3 → f=8'h02, carry=0.
- mul: select=10, x=4'hF, y=4'hF → out_valid rises exactly 5 cycles after accept with f=8'hE1. During the 4 MUL cycles in_ready=0.
  - Repeat with y=0 → f=8'h00, zero=1, same latency.
- Backpressure: complete an add with out_ready=0 for 3 cycles → f stable, in_ready=0. Then raise out_ready with in_valid and select=11, x=4'hA in the same cycle → accepted that cycle, next result f=8'h0A.
- Abort: accept mul 7*9, drop rst_n in 2nd MUL cycle → no out_valid for that op. After release, a new mul 2*3 gives f=8'h06 with normal 5-cycle latency.
